exc_commit_arbiter: RTL and testbench

- Parametrised exception commit unit at the memory/commit stage of the MIPS pipeline.
- Arbitrates one interrupt group, NUM_SRC prioritised synchronous exception sources and ERET, then drives CP0 write-back (ExcCode, EPC, BadVAddr, EXL).
- Computes the redirect PC, including MIPS32r2 vectored-interrupt offsets.
- Holds a multi-stage flush until the fetch unit acknowledges the redirect.

---
 rtl/exc_commit_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_exc_commit_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit_arbiter.sv
// Exception commit arbiter: picks interrupt, synchronous exception or ERET at commit,
// drives CP0 write-back and the redirect PC, and holds the pipeline flush until fetch accepts.
module exc_commit_arbiter #(
  parameter int                 NUM_SRC     = 12,
  parameter int                 NUM_FLUSH   = 3,
  parameter int                 NUM_INT     = 8,
  parameter logic [NUM_SRC-1:0] REFILL_MASK = '0,
  parameter logic [NUM_SRC-1:0] DADDR_MASK  = '0,
  parameter logic [NUM_SRC-1:0] BADV_MASK   = '0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [5*NUM_SRC-1:0]   src_code,
  input  logic [NUM_INT-1:0]     int_pending,
  input  logic                   int_enable,
  input  logic                   eret,
  input  logic [31:0]            pc,
  input  logic [31:0]            data_vaddr,
  input  logic [31:0]            cur_epc,
  input  logic [31:0]            epc_in,
  input  logic [31:0]            ebase,
  input  logic                   sr_bev,
  input  logic                   sr_exl,
  input  logic                   cause_iv,
  input  logic [4:0]             intctl_vs,
  input  logic                   fetch_ok,
  output logic                   exc_pending,
  output logic                   busy,
  output logic [NUM_FLUSH-1:0]   flush,
  output logic                   cp0_wr_exp,
  output logic                   clear_exl,
  output logic [4:0]             exc_code,
  output logic [31:0]            epc,
  output logic [31:0]            badvaddr,
  output logic                   badvaddr_we,
  output logic [31:0]            new_pc
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e               state_q, state_d;
  logic [NUM_FLUSH-1:0] flush_q, flush_d;
  logic                 cp0_wr_exp_q, cp0_wr_exp_d;
  logic                 clear_exl_q, clear_exl_d;
  logic                 badvaddr_we_q, badvaddr_we_d;
  logic [4:0]           exc_code_q, exc_code_d;
  logic [31:0]          epc_q, epc_d;
  logic [31:0]          badvaddr_q, badvaddr_d;
  logic [31:0]          new_pc_q, new_pc_d;

  logic        int_take;
  logic        src_hit;
  logic [4:0]  src_code_sel;
  logic        src_refill;
  logic        src_daddr;
  logic        src_badv;
  logic [31:0] int_num;
  logic [31:0] vec_base;
  logic [31:0] vec_spacing;
  logic [31:0] int_vec;

  assign int_take = int_enable && (|int_pending);

  // Descending scan so the lowest-numbered raised source is the one left selected.
  always_comb begin
    src_hit      = 1'b0;
    src_code_sel = '0;
    src_refill   = 1'b0;
    src_daddr    = 1'b0;
    src_badv     = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        src_hit      = 1'b1;
        src_code_sel = src_code[5*i +: 5];
        src_refill   = REFILL_MASK[i];
        src_daddr    = DADDR_MASK[i];
        src_badv     = BADV_MASK[i];
      end
    end
  end

  // Vectored interrupts use the highest pending line number.
  always_comb begin
    int_num = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (int_pending[i]) int_num = 32'(i);
    end
  end

  assign vec_base    = sr_bev ? 32'hBFC0_0200 : ebase;
  assign vec_spacing = {22'd0, intctl_vs, 5'd0};

  always_comb begin
    if (!cause_iv)                         int_vec = vec_base + 32'h180;
    else if (sr_bev || intctl_vs == 5'd0)  int_vec = vec_base + 32'h200;
    else                                   int_vec = vec_base + 32'h200 + int_num * vec_spacing;
  end

  assign exc_pending = (state_q == IDLE) && (int_take || src_hit || eret);

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    flush_d       = flush_q;
    cp0_wr_exp_d  = 1'b0;
    clear_exl_d   = 1'b0;
    badvaddr_we_d = 1'b0;
    badvaddr_d    = badvaddr_q;
    exc_code_d    = exc_code_q;
    epc_d         = epc_q;
    new_pc_d      = new_pc_q;
    case (state_q)
      IDLE: begin
        flush_d    = '0;
        badvaddr_d = '0;
        if (int_take) begin
          state_d      = HOLD;
          flush_d      = '1;
          cp0_wr_exp_d = 1'b1;
          exc_code_d   = 5'd0;
          epc_d        = cur_epc;
          new_pc_d     = int_vec;
        end else if (src_hit) begin
          state_d      = HOLD;
          flush_d      = '1;
          cp0_wr_exp_d = 1'b1;
          exc_code_d   = src_code_sel;
          if (src_refill) begin
            new_pc_d = sr_exl ? vec_base + 32'h180 : vec_base;
            epc_d    = sr_exl ? epc_in : cur_epc;
          end else begin
            new_pc_d = vec_base + 32'h180;
            epc_d    = cur_epc;
          end
          if (src_badv) begin
            badvaddr_we_d = 1'b1;
            badvaddr_d    = src_daddr ? data_vaddr : pc;
          end
        end else if (eret) begin
          state_d     = HOLD;
          flush_d     = '1;
          clear_exl_d = 1'b1;
          new_pc_d    = epc_in;
        end
      end
      HOLD: begin
        // Only the fetch handshake matters here; the squashed pipeline is ignored.
        if (fetch_ok) begin
          state_d    = IDLE;
          flush_d    = '0;
          badvaddr_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        flush_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      flush_q       <= '0;
      cp0_wr_exp_q  <= 1'b0;
      clear_exl_q   <= 1'b0;
      badvaddr_we_q <= 1'b0;
      exc_code_q    <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      new_pc_q      <= '0;
    end else begin
      state_q       <= state_d;
      flush_q       <= flush_d;
      cp0_wr_exp_q  <= cp0_wr_exp_d;
      clear_exl_q   <= clear_exl_d;
      badvaddr_we_q <= badvaddr_we_d;
      exc_code_q    <= exc_code_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      new_pc_q      <= new_pc_d;
    end
  end

  assign busy        = (state_q == HOLD);
  assign flush       = flush_q;
  assign cp0_wr_exp  = cp0_wr_exp_q;
  assign clear_exl   = clear_exl_q;
  assign badvaddr_we = badvaddr_we_q;
  assign exc_code    = exc_code_q;
  assign epc         = epc_q;
  assign badvaddr    = badvaddr_q;
  assign new_pc      = new_pc_q;

endmodule

// File: tb/tb_exc_commit_arbiter.sv
// Scoreboard bench for exc_commit_arbiter: directed scenarios plus randomized events,
// with a reference model that derives each commit result from the architectural rules.
module tb_exc_commit_arbiter;

  localparam int          NUM_SRC   = 12;
  localparam int          NUM_FLUSH = 3;
  localparam int          NUM_INT   = 8;
  localparam logic [11:0] REFILL_M  = 12'h820;
  localparam logic [11:0] DADDR_M   = 12'h0C4;
  localparam logic [11:0] BADV_M    = 12'h0C6;

  logic                 clk, resetn;
  logic [NUM_SRC-1:0]   src_valid;
  logic [5*NUM_SRC-1:0] src_code;
  logic [NUM_INT-1:0]   int_pending;
  logic                 int_enable, eret;
  logic [31:0]          pc, data_vaddr, cur_epc, epc_in, ebase;
  logic                 sr_bev, sr_exl, cause_iv;
  logic [4:0]           intctl_vs;
  logic                 fetch_ok;
  logic                 exc_pending, busy, cp0_wr_exp, clear_exl, badvaddr_we;
  logic [NUM_FLUSH-1:0] flush;
  logic [4:0]           exc_code;
  logic [31:0]          epc, badvaddr, new_pc;

  exc_commit_arbiter #(
    .NUM_SRC(NUM_SRC), .NUM_FLUSH(NUM_FLUSH), .NUM_INT(NUM_INT),
    .REFILL_MASK(REFILL_M), .DADDR_MASK(DADDR_M), .BADV_MASK(BADV_M)
  ) dut (
    .clk(clk), .resetn(resetn), .src_valid(src_valid), .src_code(src_code),
    .int_pending(int_pending), .int_enable(int_enable), .eret(eret), .pc(pc),
    .data_vaddr(data_vaddr), .cur_epc(cur_epc), .epc_in(epc_in), .ebase(ebase),
    .sr_bev(sr_bev), .sr_exl(sr_exl), .cause_iv(cause_iv), .intctl_vs(intctl_vs),
    .fetch_ok(fetch_ok), .exc_pending(exc_pending), .busy(busy), .flush(flush),
    .cp0_wr_exp(cp0_wr_exp), .clear_exl(clear_exl), .exc_code(exc_code), .epc(epc),
    .badvaddr(badvaddr), .badvaddr_we(badvaddr_we), .new_pc(new_pc)
  );

  typedef struct packed {
    logic [11:0] sv;
    logic [59:0] codes;
    logic [7:0]  ip;
    logic        ie, er;
    logic [31:0] pc, dva, cepc, epci, eb;
    logic        bev, exl, iv;
    logic [4:0]  vs;
  } stim_t;

  typedef struct packed {
    logic        wr, clr, bwe;
    logic [4:0]  code;
    logic [31:0] epc, npc, badv;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, failures = 0, pushes = 0, pops = 0;
  logic [4:0]  m_code = '0;
  logic [31:0] m_epc = '0, m_npc = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the commit stage must report for one accepted event.
  function automatic exp_t model(stim_t s);
    exp_t        e;
    int          idx;
    logic [31:0] base, n;
    e    = '0;
    base = s.bev ? 32'hBFC00200 : s.eb;
    idx  = -1;
    for (int i = 0; i < NUM_SRC; i++) if (s.sv[i] && idx < 0) idx = i;
    if (s.ie && s.ip != 0) begin
      e.wr  = 1'b1;
      e.epc = s.cepc;
      n     = 0;
      for (int i = 0; i < NUM_INT; i++) if (s.ip[i]) n = 32'(i);
      if (!s.iv)                     e.npc = base + 32'h180;
      else if (s.bev || s.vs == 0)   e.npc = base + 32'h200;
      else                           e.npc = base + 32'h200 + n * (32'(s.vs) * 32);
    end else if (idx >= 0) begin
      e.wr   = 1'b1;
      e.code = s.codes[5*idx +: 5];
      if (REFILL_M[idx]) begin
        e.npc = s.exl ? base + 32'h180 : base;
        e.epc = s.exl ? s.epci : s.cepc;
      end else begin
        e.npc = base + 32'h180;
        e.epc = s.cepc;
      end
      if (BADV_M[idx]) begin
        e.bwe  = 1'b1;
        e.badv = DADDR_M[idx] ? s.dva : s.pc;
      end
    end else begin
      e.clr  = 1'b1;
      e.npc  = s.epci;
      e.code = m_code;
      e.epc  = m_epc;
    end
    return e;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.sv    = ($urandom_range(0, 3) == 0) ? 12'h0 : 12'($urandom & $urandom & $urandom);
    s.codes = 60'({$urandom, $urandom});
    s.ip    = ($urandom_range(0, 1) == 0) ? 8'h0 : 8'($urandom);
    s.ie    = ($urandom_range(0, 2) == 0);
    s.er    = 1'($urandom_range(0, 1));
    s.pc    = $urandom;
    s.dva   = $urandom;
    s.cepc  = $urandom;
    s.epci  = $urandom;
    s.eb    = $urandom & 32'hFFFF_F000;
    s.bev   = ($urandom_range(0, 3) == 0);
    s.exl   = 1'($urandom_range(0, 1));
    s.iv    = 1'($urandom_range(0, 1));
    s.vs    = 5'($urandom);
    if (!(s.ie && s.ip != 0) && s.sv == 0) s.er = 1'b1;
    return s;
  endfunction

  task automatic apply(stim_t s);
    src_valid = s.sv;   src_code = s.codes; int_pending = s.ip; int_enable = s.ie;
    eret = s.er;        pc = s.pc;          data_vaddr = s.dva; cur_epc = s.cepc;
    epc_in = s.epci;    ebase = s.eb;       sr_bev = s.bev;     sr_exl = s.exl;
    cause_iv = s.iv;    intctl_vs = s.vs;
  endtask

  task automatic clear_events();
    src_valid = '0; int_pending = '0; int_enable = 1'b0; eret = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_flush"}, 32'(flush), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_pending"}, 32'(exc_pending), 0);
    check({tag, "_cp0_wr"}, 32'(cp0_wr_exp), 0);
    check({tag, "_clear_exl"}, 32'(clear_exl), 0);
    check({tag, "_code"}, 32'(exc_code), 0);
    check({tag, "_epc"}, epc, 0);
    check({tag, "_badv"}, badvaddr, 0);
    check({tag, "_badv_we"}, 32'(badvaddr_we), 0);
    check({tag, "_new_pc"}, new_pc, 0);
  endtask

  // Called at a falling edge while idle; returns at a falling edge back in idle.
  task automatic do_txn(stim_t s, int hold_extra, bit fetch_at_t, bit ones_hold, bit reset_mid);
    exp_t  e;
    stim_t g;
    apply(s);
    fetch_ok = fetch_at_t;
    #1;
    check("exc_pending", 32'(exc_pending), 1);
    check("busy_before", 32'(busy), 0);
    e = model(s);
    exp_q.push_back(e);
    pushes++;
    if (e.wr) begin
      m_code = e.code;
      m_epc  = e.epc;
    end
    m_npc = e.npc;
    @(negedge clk);
    check("busy_t1", 32'(busy), 1);
    check("flush_t1", 32'(flush), 32'h7);
    if (reset_mid) begin
      clear_events();
      fetch_ok = 1'b0;
      #2 resetn = 1'b0;
      #1 check_all_zero("reset_mid_hold");
      m_code = '0; m_epc = '0; m_npc = '0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("after_reset_flush", 32'(flush), 0);
      check("after_reset_busy", 32'(busy), 0);
      return;
    end
    for (int k = 0; k < hold_extra; k++) begin
      g = rand_stim();
      if (ones_hold) g.sv = '1;
      apply(g);
      fetch_ok = 1'b0;
      @(negedge clk);
      check("hold_busy", 32'(busy), 1);
      check("hold_flush", 32'(flush), 32'h7);
      check("hold_cp0_wr", 32'(cp0_wr_exp), 0);
      check("hold_clear_exl", 32'(clear_exl), 0);
      check("hold_badv_we", 32'(badvaddr_we), 0);
      check("hold_badv", badvaddr, e.badv);
      check("hold_new_pc", new_pc, m_npc);
      check("hold_code", 32'(exc_code), 32'(m_code));
      check("hold_epc", epc, m_epc);
    end
    clear_events();
    fetch_ok = 1'b1;
    @(negedge clk);
    fetch_ok = 1'b0;
    check("release_busy", 32'(busy), 0);
    check("release_flush", 32'(flush), 0);
    check("release_pulses", {29'd0, cp0_wr_exp, clear_exl, badvaddr_we}, 0);
    check("release_badv", badvaddr, 0);
    check("release_new_pc", new_pc, m_npc);
    check("release_code", 32'(exc_code), 32'(m_code));
    check("release_epc", epc, m_epc);
  endtask

  task automatic idle_cycle();
    clear_events();
    @(negedge clk);
    check("idle_pending", 32'(exc_pending), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_flush", 32'(flush), 0);
    check("idle_pulses", {29'd0, cp0_wr_exp, clear_exl, badvaddr_we}, 0);
    check("idle_badv", badvaddr, 0);
    check("idle_new_pc", new_pc, m_npc);
    check("idle_code", 32'(exc_code), 32'(m_code));
  endtask

  // Monitor: every commit pulse retires one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && (cp0_wr_exp || clear_exl)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: cp0_wr_exp=%b clear_exl=%b with no event outstanding at %0t",
                 cp0_wr_exp, clear_exl, $time);
      end else begin
        e = exp_q.pop_front();
        pops++;
        check("sb_cp0_wr", 32'(cp0_wr_exp), 32'(e.wr));
        check("sb_clear_exl", 32'(clear_exl), 32'(e.clr));
        check("sb_badv_we", 32'(badvaddr_we), 32'(e.bwe));
        check("sb_badv", badvaddr, e.badv);
        check("sb_code", 32'(exc_code), 32'(e.code));
        check("sb_epc", epc, e.epc);
        check("sb_new_pc", new_pc, e.npc);
        check("sb_flush", 32'(flush), 32'h7);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t d;
    resetn = 1'b0;
    fetch_ok = 1'b0;
    apply('0);
    #12 check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_after_reset_flush", 32'(flush), 0);
    check("idle_after_reset_busy", 32'(busy), 0);

    // Two raised sources, lower index wins; badvaddr from pc; fetch at T+3.
    d = '0;
    d.sv = 12'h006; d.codes[9:5] = 5'd4; d.pc = 32'h80001000; d.eb = 32'h80000000;
    d.dva = 32'h12345678; d.cepc = 32'h80000ffc;
    do_txn(d, 2, 1'b0, 1'b0, 1'b0);
    check("t2_new_pc", new_pc, 32'h80000180);
    check("t2_code", 32'(exc_code), 4);

    // Refill source with and without EXL.
    d = '0;
    d.sv = 12'h020; d.codes[29:25] = 5'd2; d.eb = 32'h80000000;
    d.cepc = 32'h80004000; d.epci = 32'h80005000;
    do_txn(d, 0, 1'b1, 1'b0, 1'b0);
    check("t3_new_pc", new_pc, 32'h80000000);
    check("t3_epc", epc, 32'h80004000);
    d.exl = 1'b1;
    do_txn(d, 1, 1'b0, 1'b0, 1'b0);
    check("t3_exl_new_pc", new_pc, 32'h80000180);
    check("t3_exl_epc", epc, 32'h80005000);

    // Vectored interrupt, then BEV forces the common vector.
    d = '0;
    d.ie = 1'b1; d.ip = 8'h24; d.iv = 1'b1; d.vs = 5'd1; d.eb = 32'h80000000;
    d.sv = 12'h001; d.cepc = 32'h80006000;
    do_txn(d, 1, 1'b0, 1'b0, 1'b0);
    check("t4_new_pc", new_pc, 32'h800002A0);
    check("t4_code", 32'(exc_code), 0);
    d.bev = 1'b1;
    do_txn(d, 0, 1'b0, 1'b0, 1'b0);
    check("t4_bev_new_pc", new_pc, 32'hBFC00400);

    // ERET alone, then ERET beaten by a synchronous exception.
    d = '0;
    d.er = 1'b1; d.epci = 32'h80002000;
    do_txn(d, 1, 1'b0, 1'b0, 1'b0);
    check("t5_new_pc", new_pc, 32'h80002000);
    d.sv = 12'h008; d.codes[19:15] = 5'd13; d.eb = 32'h80000000;
    do_txn(d, 0, 1'b0, 1'b0, 1'b0);
    check("t5_exc_code", 32'(exc_code), 13);

    // All sources hammering during HOLD, then immediate re-accept on return to idle.
    d = rand_stim();
    do_txn(d, 4, 1'b1, 1'b1, 1'b0);
    d = rand_stim();
    do_txn(d, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of HOLD.
    d = rand_stim();
    do_txn(d, 0, 1'b0, 1'b0, 1'b1);
    idle_cycle();

    for (int n = 0; n < 300; n++) begin
      d = rand_stim();
      do_txn(d, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("pulses_seen", pops, pushes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
